// File: rtl/byte_burst_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : byte_burst_fifo_pkg
// Brief    : Shared FIFO entry layout and time-slot constants.
// Revision : 1.0
// ============================================================================
package byte_burst_fifo_pkg;

  localparam int ENT_W   = 11;
  localparam int ENT_TS  = 10;
  localparam int ENT_SOF = 9;
  localparam int ENT_EOF = 8;

  localparam logic TS0 = 1'b0;
  localparam logic TS1 = 1'b1;

  function automatic logic [ENT_W-1:0] pack_entry(
    input logic       ts,
    input logic       sof,
    input logic       eof,
    input logic [7:0] data
  );
    return {ts, sof, eof, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_burst_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_burst_fifo_sync_fifo
// Brief    : Synchronous FIFO with a registered first-word-fall-through head.
// Revision : 1.0
// ============================================================================
module byte_burst_fifo_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_level,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_rdata;

  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;
  logic [AW:0]      w_rd_next;
  logic             w_avail;

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = r_valid & i_ready;
  assign w_wr_en   = i_push & (~w_full | w_pop);
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};
  // The head entry stays in memory until popped; the register is just a copy.
  assign w_avail   = (r_wr_ptr != w_rd_next);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_wr_en};
      r_rd_ptr <= w_rd_next;
      r_valid  <= w_avail;
      if (w_avail) begin
        r_rdata <= r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_rdata;
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_drop  = i_push & w_full & ~w_pop;

endmodule
`default_nettype wire

// File: rtl/byte_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_burst_fifo
// Brief    : Tags packed bytes with time slot and burst framing, then buffers.
// Revision : 1.0
// ============================================================================
module byte_burst_fifo
  import byte_burst_fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_sync,
  input  logic [7:0]  byte_data,
  input  logic        byte_win0,
  input  logic        byte_win1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_ts,
  output logic        out_sof,
  output logic        out_eof,
  output logic        ovf,
  output logic        win_err,
  input  logic        err_clr,
  output logic [AW:0] fifo_level
);

  logic             r_stg_valid;
  logic [7:0]       r_stg_data;
  logic             r_stg_ts;
  logic             r_stg_sof;
  logic [1:0]       r_in_burst;
  logic             r_ovf;
  logic             r_win_err;

  logic [1:0]       w_win;
  logic             w_acc;
  logic             w_ts;
  logic             w_both;
  logic             w_sof;
  logic             w_stg_win_low;
  logic             w_push;
  logic             w_eof;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_rdata;
  logic             w_drop;

  assign w_win  = {byte_win1, byte_win0};
  assign w_acc  = byte_sync & (byte_win0 | byte_win1);
  assign w_ts   = byte_win0 ? TS0 : TS1;
  assign w_both = byte_sync & byte_win0 & byte_win1;

  // A burst stays open per slot until its window is seen low.
  assign w_sof = ~r_in_burst[w_ts] | (r_stg_valid & (w_ts != r_stg_ts));

  assign w_stg_win_low = r_stg_valid & ~w_win[r_stg_ts];
  assign w_push        = r_stg_valid & (w_acc | w_stg_win_low);
  assign w_eof         = w_stg_win_low | (w_ts != r_stg_ts);
  assign w_entry       = pack_entry(r_stg_ts, r_stg_sof, w_eof, r_stg_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
      r_stg_ts    <= TS0;
      r_stg_sof   <= 1'b0;
      r_in_burst  <= '0;
      r_ovf       <= 1'b0;
      r_win_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_stg_valid <= 1'b1;
        r_stg_data  <= byte_data;
        r_stg_ts    <= w_ts;
        r_stg_sof   <= w_sof;
      end else if (w_stg_win_low) begin
        r_stg_valid <= 1'b0;
      end
      r_in_burst[0] <= (w_acc & (w_ts == TS0)) | (r_in_burst[0] & byte_win0);
      r_in_burst[1] <= (w_acc & (w_ts == TS1)) | (r_in_burst[1] & byte_win1);
      // A new error in the clearing cycle keeps the flag set.
      r_ovf     <= w_drop | (r_ovf & ~err_clr);
      r_win_err <= w_both | (r_win_err & ~err_clr);
    end
  end

  byte_burst_fifo_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_rdata (w_rdata),
    .o_level (fifo_level),
    .o_drop  (w_drop)
  );

  assign out_data = w_rdata[7:0];
  assign out_ts   = w_rdata[ENT_TS];
  assign out_sof  = w_rdata[ENT_SOF];
  assign out_eof  = w_rdata[ENT_EOF];
  assign ovf      = r_ovf;
  assign win_err  = r_win_err;

endmodule
`default_nettype wire

// File: tb/tb_byte_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_burst_fifo
// Brief    : Directed self-checking bench for byte_burst_fifo (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_byte_burst_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_sync = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_win0 = 1'b0;
  logic        byte_win1 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_ts;
  logic        out_sof;
  logic        out_eof;
  logic        ovf;
  logic        win_err;
  logic        err_clr = 1'b0;
  logic [AW:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] cap [$];

  byte_burst_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_sync  (byte_sync),
    .byte_data  (byte_data),
    .byte_win0  (byte_win0),
    .byte_win1  (byte_win1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ts     (out_ts),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .ovf        (ovf),
    .win_err    (win_err),
    .err_clr    (err_clr),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Record every accepted output entry as {ts, sof, eof, data}.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      cap.push_back({out_ts, out_sof, out_eof, out_data});
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ent(input logic ts, input logic sof,
                                      input logic eof, input logic [7:0] d);
    return {ts, sof, eof, d};
  endfunction

  task automatic check_entry(input string tag, input int idx, input logic [10:0] exp);
    logic [10:0] got;
    got = (idx < cap.size()) ? cap[idx] : 11'h7FF;
    check($sformatf("%s[%0d]", tag, idx), int'(got), int'(exp));
  endtask

  task automatic drive(input logic s, input logic [7:0] d, input logic w0, input logic w1);
    byte_sync = s;
    byte_data = d;
    byte_win0 = w0;
    byte_win1 = w1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", int'(out_valid), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_win_err", int'(win_err), 0);

    // Single TS0 burst, drained immediately.
    out_ready = 1'b1;
    cap.delete();
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    idle(6);
    check("t1_count", cap.size(), 3);
    check_entry("t1", 0, ent(1'b0, 1'b1, 1'b0, 8'h11));
    check_entry("t1", 1, ent(1'b0, 1'b0, 1'b0, 8'h22));
    check_entry("t1", 2, ent(1'b0, 1'b0, 1'b1, 8'h33));
    check("t1_level", int'(fifo_level), 0);

    // TS0 burst handing straight over to a TS1 burst.
    cap.delete();
    drive(1'b1, 8'hA0, 1'b1, 1'b0);
    drive(1'b1, 8'hA1, 1'b1, 1'b0);
    drive(1'b1, 8'hB0, 1'b0, 1'b1);
    drive(1'b1, 8'hB1, 1'b0, 1'b1);
    idle(6);
    check("t2_count", cap.size(), 4);
    check_entry("t2", 0, ent(1'b0, 1'b1, 1'b0, 8'hA0));
    check_entry("t2", 1, ent(1'b0, 1'b0, 1'b1, 8'hA1));
    check_entry("t2", 2, ent(1'b1, 1'b1, 1'b0, 8'hB0));
    check_entry("t2", 3, ent(1'b1, 1'b0, 1'b1, 8'hB1));

    // Overflow with the consumer stalled.
    cap.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
    idle(4);
    check("t3_level_full", int'(fifo_level), 4);
    check("t3_ovf", int'(ovf), 1);
    check("t3_valid", int'(out_valid), 1);
    check("t3_head_hold", int'(out_data), 'hC0);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t3_ovf_clr", int'(ovf), 0);
    out_ready = 1'b1;
    idle(8);
    check("t3_count", cap.size(), 4);
    check_entry("t3", 0, ent(1'b0, 1'b1, 1'b0, 8'hC0));
    check_entry("t3", 1, ent(1'b0, 1'b0, 1'b0, 8'hC1));
    check_entry("t3", 2, ent(1'b0, 1'b0, 1'b0, 8'hC2));
    check_entry("t3", 3, ent(1'b0, 1'b0, 1'b0, 8'hC3));
    check("t3_level_empty", int'(fifo_level), 0);

    // Both windows high on one strobe.
    cap.delete();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    idle(6);
    check("t4_win_err", int'(win_err), 1);
    check("t4_count", cap.size(), 1);
    check_entry("t4", 0, ent(1'b0, 1'b1, 1'b1, 8'h5A));
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t4_win_err_clr", int'(win_err), 0);

    // Strobes outside any window are ignored.
    cap.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h77, 1'b0, 1'b0);
    idle(4);
    check("t5_level", int'(fifo_level), 0);
    check("t5_count", cap.size(), 0);
    check("t5_valid", int'(out_valid), 0);

    // Reset in the middle of a burst; window stays high across it.
    cap.delete();
    drive(1'b1, 8'hD0, 1'b1, 1'b0);
    drive(1'b1, 8'hD1, 1'b1, 1'b0);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    check("t6_valid", int'(out_valid), 0);
    check("t6_level", int'(fifo_level), 0);
    drive(1'b1, 8'hE0, 1'b1, 1'b0);
    drive(1'b1, 8'hE1, 1'b1, 1'b0);
    idle(6);
    check("t6_count", cap.size(), 2);
    check_entry("t6", 0, ent(1'b0, 1'b1, 1'b0, 8'hE0));
    check_entry("t6", 1, ent(1'b0, 1'b0, 1'b1, 8'hE1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
